// File: rtl/mux_demux_pkg.sv
// rtl/mux_demux_pkg.sv - shared constants and helpers for the shared-lane router
package mux_demux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Channel index width; a single channel still carries a 1-bit tag.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - fixed-select / round-robin arbiter with internal pointer
module rr_arbiter_n
    import mux_demux_pkg::*;
#(
    parameter  int N   = 2,
    localparam int CHW = chan_w(N)
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic [N-1:0]   req,
    input  logic           mode,
    input  logic [CHW-1:0] sel,
    input  logic           en,
    output logic [N-1:0]   grant,
    output logic [CHW-1:0] idx
);

    logic [CHW-1:0] ptr;
    logic           found;
    int             j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        if (mode == MODE_FIXED) begin
            // Comparing against each legal index makes sel >= N grant nothing.
            for (int i = 0; i < N; i++) begin
                if (sel == CHW'(i) && req[i]) begin
                    grant[i] = 1'b1;
                    idx      = CHW'(i);
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                j = int'(ptr) + k;
                if (j >= N) begin
                    j = j - N;
                end
                if (!found && req[j]) begin
                    found    = 1'b1;
                    grant[j] = 1'b1;
                    idx      = CHW'(j);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (en && |grant) begin
            ptr <= (idx == CHW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/mux_to_demux_n.sv
// rtl/mux_to_demux_n.sv - N-channel arbitrated shared pipeline lane with tag demux
module mux_to_demux_n
    import mux_demux_pkg::*;
#(
    parameter  int ID     = 1,
    parameter  int WIDTH  = 2,
    parameter  int N      = 2,
    parameter  int STAGES = 1,
    localparam int CHW    = chan_w(N)
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      mode,
    input  logic [CHW-1:0]            sel,
    input  logic [N-1:0][WIDTH-1:0]   in_data,
    input  logic [N-1:0]              in_valid,
    output logic [N-1:0]              in_ready,
    output logic [N-1:0][WIDTH-1:0]   out_data,
    output logic [N-1:0]              out_valid,
    input  logic [N-1:0]              out_ready
);

    if (ID < 0 || WIDTH < 1 || N < 1 || STAGES < 1) begin : g_bad_params
        $error("mux_to_demux_n: illegal parameter value");
    end

    logic             st_valid [STAGES];
    logic [CHW-1:0]   st_tag   [STAGES];
    logic [WIDTH-1:0] st_data  [STAGES];

    logic [N-1:0]     grant;
    logic [CHW-1:0]   grant_idx;
    logic             stall;
    logic             accept;

    // A blocked head freezes the whole lane; bubbles are not collapsed.
    assign stall    = st_valid[STAGES-1] & ~out_ready[st_tag[STAGES-1]];
    assign in_ready = (resetn && !stall) ? grant : '0;
    assign accept   = |(in_valid & in_ready);

    rr_arbiter_n #(.N(N)) u_arb (
        .clock  (clock),
        .resetn (resetn),
        .req    (in_valid),
        .mode   (mode),
        .sel    (sel),
        .en     (resetn & ~stall),
        .grant  (grant),
        .idx    (grant_idx)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            st_valid[0] <= 1'b0;
            st_tag[0]   <= '0;
            st_data[0]  <= '0;
        end else if (accept) begin
            st_valid[0] <= 1'b1;
            st_tag[0]   <= grant_idx;
            st_data[0]  <= in_data[grant_idx];
        end else if (!stall) begin
            st_valid[0] <= 1'b0;
        end
    end

    for (genvar s = 1; s < STAGES; s++) begin : g_stage
        always_ff @(posedge clock) begin
            if (!resetn) begin
                st_valid[s] <= 1'b0;
                st_tag[s]   <= '0;
                st_data[s]  <= '0;
            end else if (!stall) begin
                st_valid[s] <= st_valid[s-1];
                st_tag[s]   <= st_tag[s-1];
                st_data[s]  <= st_data[s-1];
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (resetn && st_tag[STAGES-1] == CHW'(i)) begin
                out_valid[i] = st_valid[STAGES-1];
                out_data[i]  = st_data[STAGES-1];
            end
        end
    end

endmodule

// File: tb/tb_mux_to_demux_n.sv
// tb/tb_mux_to_demux_n.sv - self-checking bench for mux_to_demux_n
module tb_mux_to_demux_n;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instance A: N=4, WIDTH=8, STAGES=2 (directed tests)
    logic             a_resetn, a_mode;
    logic [1:0]       a_sel;
    logic [3:0][7:0]  a_in_data, a_out_data;
    logic [3:0]       a_in_valid, a_in_ready, a_out_valid, a_out_ready;

    mux_to_demux_n #(.ID(1), .WIDTH(8), .N(4), .STAGES(2)) dut_a (
        .clock(clock), .resetn(a_resetn), .mode(a_mode), .sel(a_sel),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    // Instance B: N=3, WIDTH=8, STAGES=3 (random scoreboard)
    logic             b_resetn, b_mode;
    logic [1:0]       b_sel;
    logic [2:0][7:0]  b_in_data, b_out_data;
    logic [2:0]       b_in_valid, b_in_ready, b_out_valid, b_out_ready;

    mux_to_demux_n #(.ID(2), .WIDTH(8), .N(3), .STAGES(3)) dut_b (
        .clock(clock), .resetn(b_resetn), .mode(b_mode), .sel(b_sel),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic [3:0] ready;
    } vec_t;

    typedef struct {
        bit         v;
        int         tag;
        logic [7:0] data;
    } slot_t;

    localparam int NV = 18;
    vec_t vt [NV];

    slot_t      lane [$];
    logic [7:0] exp_q [3][$];
    int         ptr_m;
    int         g;
    bit         stall_m;
    logic [2:0] exp_ready;
    slot_t      head, s0, nxt;
    logic [3:0] exp_ov;

    initial begin
        vt[0]  = '{1'b1, 2'd0, 4'b1111, 4'b0001};
        vt[1]  = '{1'b1, 2'd0, 4'b1111, 4'b0010};
        vt[2]  = '{1'b1, 2'd0, 4'b1111, 4'b0100};
        vt[3]  = '{1'b1, 2'd0, 4'b1111, 4'b1000};
        vt[4]  = '{1'b1, 2'd0, 4'b1111, 4'b0001};
        vt[5]  = '{1'b1, 2'd0, 4'b1111, 4'b0010};
        vt[6]  = '{1'b1, 2'd0, 4'b1111, 4'b0100};
        vt[7]  = '{1'b1, 2'd0, 4'b1111, 4'b1000};
        vt[8]  = '{1'b1, 2'd0, 4'b0011, 4'b0001};
        vt[9]  = '{1'b1, 2'd0, 4'b1100, 4'b0100};
        vt[10] = '{1'b1, 2'd0, 4'b0110, 4'b0010};
        vt[11] = '{1'b0, 2'd2, 4'b1111, 4'b0100};
        vt[12] = '{1'b0, 2'd2, 4'b1011, 4'b0000};
        vt[13] = '{1'b0, 2'd3, 4'b1111, 4'b1000};
        vt[14] = '{1'b1, 2'd0, 4'b0000, 4'b0000};
        vt[15] = '{1'b1, 2'd0, 4'b0101, 4'b0001};
        vt[16] = '{1'b1, 2'd0, 4'b0101, 4'b0100};
        vt[17] = '{1'b1, 2'd0, 4'b0001, 4'b0001};

        a_resetn = 1'b0; a_mode = 1'b1; a_sel = 2'd0;
        a_in_valid = 4'b1111; a_out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) a_in_data[i] = 8'hF0 + 8'(i);
        b_resetn = 1'b0; b_mode = 1'b1; b_sel = 2'd0;
        b_in_valid = '0; b_out_ready = '1; b_in_data = '0;

        // Reset held with every producer requesting
        repeat (3) begin
            @(negedge clock);
            check("reset_in_ready", a_in_ready, 4'b0000);
            check("reset_out_valid", a_out_valid, 4'b0000);
            check("reset_out_data", a_out_data, 32'h0);
            @(posedge clock); #1;
        end
        a_resetn = 1'b1;

        // Arbitration table; each accepted word reappears STAGES=2 cycles later
        for (int j = 0; j < NV + 2; j++) begin
            if (j < NV) begin
                a_mode = vt[j].mode; a_sel = vt[j].sel; a_in_valid = vt[j].valid;
            end else begin
                a_in_valid = 4'b0000;
            end
            for (int i = 0; i < 4; i++) a_in_data[i] = 8'(j * 4 + i);
            @(negedge clock);
            check($sformatf("tbl_in_ready[%0d]", j), a_in_ready, (j < NV) ? vt[j].ready : 4'b0000);
            exp_ov = (j >= 2) ? vt[j-2].ready : 4'b0000;
            check($sformatf("tbl_out_valid[%0d]", j), a_out_valid, exp_ov);
            for (int i = 0; i < 4; i++)
                if (exp_ov[i]) check($sformatf("tbl_out_data[%0d]", j), a_out_data[i], 8'((j - 2) * 4 + i));
            @(posedge clock); #1;
        end

        // Backpressure: ch1 word held at head while consumer 1 is not ready
        a_mode = 1'b0; a_sel = 2'd1; a_in_valid = 4'b0010; a_out_ready = 4'b1101;
        a_in_data[1] = 8'hA5;
        @(negedge clock);
        check("bp_accept_ch1", a_in_ready, 4'b0010);
        @(posedge clock); #1;
        a_mode = 1'b1; a_in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) a_in_data[i] = 8'hC0 + 8'(i);
        @(negedge clock);
        check("bp_accept_ch2", a_in_ready, 4'b0100);
        check("bp_not_yet_out", a_out_valid, 4'b0000);
        @(posedge clock); #1;
        repeat (5) begin
            @(negedge clock);
            check("bp_in_ready_frozen", a_in_ready, 4'b0000);
            check("bp_out_valid", a_out_valid, 4'b0010);
            check("bp_data_stable", a_out_data[1], 8'hA5);
            @(posedge clock); #1;
        end
        a_out_ready = 4'b1111; a_in_valid = 4'b0000;
        @(negedge clock);
        check("bp_drain1_valid", a_out_valid, 4'b0010);
        check("bp_drain1_data", a_out_data[1], 8'hA5);
        @(posedge clock); #1;
        @(negedge clock);
        check("bp_drain2_valid", a_out_valid, 4'b0100);
        check("bp_drain2_data", a_out_data[2], 8'hC2);
        @(posedge clock); #1;
        @(negedge clock);
        check("bp_drain_empty", a_out_valid, 4'b0000);
        @(posedge clock); #1;

        // Random traffic on instance B against a queue-based lane model
        lane = {};
        for (int k = 0; k < 3; k++) lane.push_back('{1'b0, 0, 8'h00});
        ptr_m = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            b_resetn = !(cyc == 0 || cyc == 4 || (cyc > 10 && cyc < 9990 && $urandom_range(0, 999) == 0));
            b_sel = 2'($urandom_range(0, 3));
            for (int i = 0; i < 3; i++) b_in_data[i] = 8'($urandom_range(0, 255));
            if (cyc < 4) begin
                b_mode = 1'b1; b_in_valid = 3'b111; b_out_ready = 3'b111;
            end else if (cyc >= 9990) begin
                b_in_valid = 3'b000; b_out_ready = 3'b111;
            end else begin
                b_mode = 1'($urandom_range(0, 1));
                for (int i = 0; i < 3; i++) begin
                    b_in_valid[i]  = ($urandom_range(0, 2) != 0);
                    b_out_ready[i] = ($urandom_range(0, 3) != 0);
                end
            end
            @(negedge clock);
            head = lane[0];
            stall_m = head.v && !b_out_ready[head.tag];
            g = -1;
            if (b_mode == 1'b0) begin
                for (int i = 0; i < 3; i++) if (int'(b_sel) == i && b_in_valid[i]) g = i;
            end else begin
                for (int k = 0; k < 3; k++)
                    if (g < 0 && b_in_valid[(ptr_m + k) % 3]) g = (ptr_m + k) % 3;
            end
            exp_ready = (b_resetn && !stall_m && g >= 0) ? 3'(1 << g) : 3'b000;
            check("rnd_in_ready", b_in_ready, exp_ready);
            check("rnd_out_valid", b_out_valid, (b_resetn && head.v) ? 3'(1 << head.tag) : 3'b000);
            for (int i = 0; i < 3; i++)
                check("rnd_out_data", b_out_data[i], (b_resetn && head.tag == i) ? head.data : 8'h00);
            for (int i = 0; i < 3; i++) begin
                if (b_out_valid[i] && b_out_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        tests++; fails++;
                        $display("FAIL sb_unexpected_word: ch%0d delivered %0h, expected none", i, b_out_data[i]);
                    end else begin
                        check($sformatf("sb_order_ch%0d", i), b_out_data[i], exp_q[i].pop_front());
                    end
                end
            end
            @(posedge clock); #1;
            if (!b_resetn) begin
                lane = {};
                for (int k = 0; k < 3; k++) lane.push_back('{1'b0, 0, 8'h00});
                ptr_m = 0;
                for (int i = 0; i < 3; i++) exp_q[i].delete();
            end else if (!stall_m) begin
                s0 = lane[2];
                if (exp_ready != 3'b000) begin
                    nxt = '{1'b1, g, b_in_data[g]};
                    exp_q[g].push_back(b_in_data[g]);
                    ptr_m = (g + 1) % 3;
                end else begin
                    nxt = '{1'b0, s0.tag, s0.data};
                end
                void'(lane.pop_front());
                lane.push_back(nxt);
            end
        end
        for (int i = 0; i < 3; i++)
            check($sformatf("sb_no_loss_ch%0d", i), exp_q[i].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
